// File: rtl/if_tracker_mo.sv
// Instruction-fetch tracker with multiple outstanding fetches.
// Timestamps request start, grant and response for every traced fetch,
// pairs responses with grants in order, and queues completed records in
// an output FIFO drained through a valid/ready handshake.
module if_tracker_mo #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TIME_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               trace_en,
    input  logic                               instr_req,
    input  logic [ADDR_WIDTH-1:0]              instr_addr,
    input  logic                               instr_grant,
    input  logic                               instr_rvalid,
    input  logic [DATA_WIDTH-1:0]              instr_rdata,
    input  logic [TIME_WIDTH-1:0]              counter,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ADDR_WIDTH-1:0]              out_addr,
    output logic [DATA_WIDTH-1:0]              out_instr,
    output logic [TIME_WIDTH-1:0]              out_t_req,
    output logic [TIME_WIDTH-1:0]              out_t_gnt,
    output logic [TIME_WIDTH-1:0]              out_t_rsp,
    output logic [$clog2(MAX_OUTSTANDING):0]   pending_count,
    output logic                               err_overflow,
    output logic                               err_spurious,
    output logic [15:0]                        drop_count
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int OW = $clog2(OUT_DEPTH);

    typedef enum logic [0:0] {REQ_IDLE, REQ_WAIT_GNT} req_state_t;

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    req_state_t            state;
    logic [TIME_WIDTH-1:0] t_req_reg;

    // Pending (granted, unanswered) FIFO storage and pointers.
    logic [ADDR_WIDTH-1:0] pend_addr [MAX_OUTSTANDING];
    logic [TIME_WIDTH-1:0] pend_treq [MAX_OUTSTANDING];
    logic [TIME_WIDTH-1:0] pend_tgnt [MAX_OUTSTANDING];
    logic [PW:0]           pend_wr;
    logic [PW:0]           pend_rd;
    logic                  pend_empty;
    logic                  pend_full;

    // Completed-record output FIFO storage and pointers.
    logic [ADDR_WIDTH-1:0] oq_addr [OUT_DEPTH];
    logic [DATA_WIDTH-1:0] oq_instr [OUT_DEPTH];
    logic [TIME_WIDTH-1:0] oq_treq [OUT_DEPTH];
    logic [TIME_WIDTH-1:0] oq_tgnt [OUT_DEPTH];
    logic [TIME_WIDTH-1:0] oq_trsp [OUT_DEPTH];
    logic [OW:0]           oq_wr;
    logic [OW:0]           oq_rd;
    logic                  oq_empty;
    logic                  oq_full;

    logic                  grant_push;
    logic [TIME_WIDTH-1:0] push_treq;
    logic                  pend_push;
    logic                  pend_pop;
    logic                  oq_pop;
    logic                  oq_push;
    logic                  oq_drop;

    assign pend_empty = (pend_wr == pend_rd);
    assign pend_full  = (pend_wr[PW] != pend_rd[PW]) &&
                        (pend_wr[PW-1:0] == pend_rd[PW-1:0]);
    assign oq_empty   = (oq_wr == oq_rd);
    assign oq_full    = (oq_wr[OW] != oq_rd[OW]) &&
                        (oq_wr[OW-1:0] == oq_rd[OW-1:0]);

    // Decide whether this cycle's grant produces a pending entry, and its start time.
    always_comb begin
        grant_push = 1'b0;
        push_treq  = t_req_reg;
        case (state)
            REQ_IDLE: begin
                if (instr_req && trace_en && instr_grant) begin
                    grant_push = 1'b1;
                    push_treq  = counter;
                end
            end
            REQ_WAIT_GNT: begin
                grant_push = instr_grant;
            end
            default: begin
                grant_push = 1'b0;
            end
        endcase
    end

    // Empty/full are judged on pre-cycle state: an rvalid pairs with the
    // existing head, and a grant into a full FIFO is refused even if a pop coincides.
    assign pend_push = grant_push && !pend_full;
    assign pend_pop  = instr_rvalid && !pend_empty;
    assign oq_pop    = !oq_empty && out_ready;
    assign oq_push   = pend_pop && (!oq_full || oq_pop);
    assign oq_drop   = pend_pop && oq_full && !oq_pop;

    // Request FSM: tracks a request from start until its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ_IDLE;
        end else begin
            case (state)
                REQ_IDLE: begin
                    if (instr_req && trace_en && !instr_grant) begin
                        state <= REQ_WAIT_GNT;
                    end
                end
                REQ_WAIT_GNT: begin
                    if (instr_grant) begin
                        state <= REQ_IDLE;
                    end
                end
                default: state <= REQ_IDLE;
            endcase
        end
    end

    // Capture the request start time when a traced request begins.
    always_ff @(posedge clk) begin
        if (state == REQ_IDLE && instr_req && trace_en) begin
            t_req_reg <= counter;
        end
    end

    // Pending FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_wr <= '0;
            pend_rd <= '0;
        end else begin
            if (pend_push) pend_wr <= pend_wr + 1'b1;
            if (pend_pop)  pend_rd <= pend_rd + 1'b1;
        end
    end

    // Pending FIFO storage.
    always_ff @(posedge clk) begin
        if (pend_push) begin
            pend_addr[pend_wr[PW-1:0]] <= instr_addr;
            pend_treq[pend_wr[PW-1:0]] <= push_treq;
            pend_tgnt[pend_wr[PW-1:0]] <= counter;
        end
    end

    // Output FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            oq_wr <= '0;
            oq_rd <= '0;
        end else begin
            if (oq_push) oq_wr <= oq_wr + 1'b1;
            if (oq_pop)  oq_rd <= oq_rd + 1'b1;
        end
    end

    // Output FIFO storage: completed record formed from the pending head.
    always_ff @(posedge clk) begin
        if (oq_push) begin
            oq_addr[oq_wr[OW-1:0]]  <= pend_addr[pend_rd[PW-1:0]];
            oq_instr[oq_wr[OW-1:0]] <= instr_rdata;
            oq_treq[oq_wr[OW-1:0]]  <= pend_treq[pend_rd[PW-1:0]];
            oq_tgnt[oq_wr[OW-1:0]]  <= pend_tgnt[pend_rd[PW-1:0]];
            oq_trsp[oq_wr[OW-1:0]]  <= counter;
        end
    end

    // Sticky error flags and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow <= 1'b0;
            err_spurious <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (grant_push && pend_full)    err_overflow <= 1'b1;
            if (instr_rvalid && pend_empty) err_spurious <= 1'b1;
            if (oq_drop)                    drop_count   <= sat_inc16(drop_count);
        end
    end

    // Record outputs read the FIFO head; forced to zero while nothing is queued.
    assign out_valid     = !oq_empty;
    assign out_addr      = out_valid ? oq_addr[oq_rd[OW-1:0]]  : '0;
    assign out_instr     = out_valid ? oq_instr[oq_rd[OW-1:0]] : '0;
    assign out_t_req     = out_valid ? oq_treq[oq_rd[OW-1:0]]  : '0;
    assign out_t_gnt     = out_valid ? oq_tgnt[oq_rd[OW-1:0]]  : '0;
    assign out_t_rsp     = out_valid ? oq_trsp[oq_rd[OW-1:0]]  : '0;
    assign pending_count = pend_wr - pend_rd;

endmodule

// File: tb/tb_if_tracker_mo.sv
// Directed bench for if_tracker_mo: single fetch, pipelined fetches,
// same-cycle grant/rvalid, overflow/spurious flags, output backpressure,
// trace_en gating and mid-operation reset.
module tb_if_tracker_mo;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_grant;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic [31:0] counter;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_instr;
    logic [31:0] out_t_req;
    logic [31:0] out_t_gnt;
    logic [31:0] out_t_rsp;
    logic [2:0]  pending_count;
    logic        err_overflow;
    logic        err_spurious;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    if_tracker_mo #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIME_WIDTH(32),
        .MAX_OUTSTANDING(4), .OUT_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_grant(instr_grant),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .counter(counter),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_instr(out_instr), .out_t_req(out_t_req), .out_t_gnt(out_t_gnt),
        .out_t_rsp(out_t_rsp), .pending_count(pending_count),
        .err_overflow(err_overflow), .err_spurious(err_spurious),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // One clock cycle with the given fetch-port inputs; the counter advances after the edge.
    task automatic cyc(input logic req, input logic [31:0] addr, input logic gnt,
                       input logic rv, input logic [31:0] rd);
        instr_req    = req;
        instr_addr   = addr;
        instr_grant  = gnt;
        instr_rvalid = rv;
        instr_rdata  = rd;
        @(posedge clk);
        #1;
        counter      = counter + 1;
        instr_req    = 1'b0;
        instr_grant  = 1'b0;
        instr_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pending_count); end
        total++; if (err_overflow !== 1'b0 || err_spurious !== 1'b0) begin bad++; $display("FAIL reset_flags got=%0b%0b exp=00", err_overflow, err_spurious); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        total++; if (out_addr !== 32'd0 || out_t_rsp !== 32'd0) begin bad++; $display("FAIL reset_record got=%0h/%0h exp=0/0", out_addr, out_t_rsp); end
    endtask

    task automatic test_single_fetch();
        counter = 32'd10;
        cyc(1, 32'hA000, 0, 0, 0);          // counter 10: request starts
        cyc(1, 32'hA000, 0, 0, 0);          // 11: waiting
        cyc(1, 32'hA000, 1, 0, 0);          // 12: grant
        total++; if (pending_count !== 3'd1) begin bad++; $display("FAIL single_pending got=%0d exp=1", pending_count); end
        cyc(0, 0, 0, 0, 0);                 // 13
        cyc(0, 0, 0, 1, 32'hDEAD0001);      // 14: rvalid
        // counter now 15
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        total++; if (out_addr !== 32'hA000 || out_instr !== 32'hDEAD0001) begin bad++; $display("FAIL single_data got=%0h/%0h exp=a000/dead0001", out_addr, out_instr); end
        total++; if (out_t_req !== 32'd10 || out_t_gnt !== 32'd12 || out_t_rsp !== 32'd14) begin bad++; $display("FAIL single_times got=%0d/%0d/%0d exp=10/12/14", out_t_req, out_t_gnt, out_t_rsp); end
        cyc(0, 0, 0, 0, 0);                 // 15: consumed
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%0b exp=0", out_valid); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL single_pending_end got=%0d exp=0", pending_count); end
    endtask

    task automatic test_pipelined();
        counter = 32'd20;
        cyc(1, 32'h100, 1, 0, 0);
        cyc(1, 32'h104, 1, 0, 0);
        cyc(1, 32'h108, 1, 0, 0);
        total++; if (pending_count !== 3'd3) begin bad++; $display("FAIL pipe_peak got=%0d exp=3", pending_count); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 32'hC0DE0000 + i);
            total++;
            if (out_valid !== 1'b1 || out_addr !== 32'h100 + 4 * i || out_instr !== 32'hC0DE0000 + i ||
                out_t_req !== 32'd20 + i || out_t_gnt !== 32'd20 + i || out_t_rsp !== 32'd23 + i) begin
                bad++;
                $display("FAIL pipe_rec%0d got=v%0b a=%0h i=%0h %0d/%0d/%0d exp=a=%0h %0d/%0d/%0d", i,
                         out_valid, out_addr, out_instr, out_t_req, out_t_gnt, out_t_rsp,
                         32'h100 + 4 * i, 20 + i, 20 + i, 23 + i);
            end
        end
        cyc(0, 0, 0, 0, 0);
        total++; if (out_valid !== 1'b0 || pending_count !== 3'd0) begin bad++; $display("FAIL pipe_drain got=v%0b p=%0d exp=v0 p0", out_valid, pending_count); end
    endtask

    task automatic test_same_cycle();
        counter = 32'd30;
        cyc(1, 32'h200, 1, 0, 0);                  // 30: one entry pending
        cyc(1, 32'h204, 1, 1, 32'h11111111);       // 31: grant + rvalid together
        total++; if (pending_count !== 3'd1) begin bad++; $display("FAIL same_pending got=%0d exp=1", pending_count); end
        total++; if (out_addr !== 32'h200 || out_t_req !== 32'd30 || out_t_rsp !== 32'd31) begin bad++; $display("FAIL same_rec got=%0h %0d/%0d exp=200 30/31", out_addr, out_t_req, out_t_rsp); end
        cyc(0, 0, 0, 1, 32'h22222222);             // 32
        total++; if (out_addr !== 32'h204 || out_t_gnt !== 32'd31 || out_t_rsp !== 32'd32 || pending_count !== 3'd0) begin bad++; $display("FAIL same_rec2 got=%0h %0d/%0d p=%0d exp=204 31/32 p0", out_addr, out_t_gnt, out_t_rsp, pending_count); end
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_overflow_spurious();
        do_reset();
        counter = 32'd40;
        for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 4 * i, 1, 0, 0);
        total++; if (err_overflow !== 1'b0 || pending_count !== 3'd4) begin bad++; $display("FAIL ovf_before got=o%0b p=%0d exp=o0 p4", err_overflow, pending_count); end
        cyc(1, 32'h310, 1, 0, 0);
        total++; if (err_overflow !== 1'b1 || pending_count !== 3'd4) begin bad++; $display("FAIL ovf_after got=o%0b p=%0d exp=o1 p4", err_overflow, pending_count); end
        do_reset();
        total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_before got=%0b exp=0", err_spurious); end
        cyc(0, 0, 0, 1, 32'h5);
        total++; if (err_spurious !== 1'b1 || out_valid !== 1'b0 || pending_count !== 3'd0) begin bad++; $display("FAIL spur_after got=s%0b v%0b p%0d exp=s1 v0 p0", err_spurious, out_valid, pending_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        counter = 32'd50;
        cyc(1, 32'h400, 1, 0, 0);
        for (int i = 1; i < 6; i++) cyc(1, 32'h400 + 4 * i, 1, 1, 32'hB0 + i - 1);
        cyc(0, 0, 0, 1, 32'hB5);
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL bp_drop got=%0d exp=2", drop_count); end
        total++; if (out_addr !== 32'h400 || out_t_rsp !== 32'd51) begin bad++; $display("FAIL bp_head got=%0h %0d exp=400 51", out_addr, out_t_rsp); end
        cyc(0, 0, 0, 0, 0);
        total++; if (out_valid !== 1'b1 || out_addr !== 32'h400 || out_instr !== 32'hB0 || out_t_req !== 32'd50) begin bad++; $display("FAIL bp_stable got=v%0b %0h %0h %0d exp=v1 400 b0 50", out_valid, out_addr, out_instr, out_t_req); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_addr !== 32'h400 + 4 * i || out_instr !== 32'hB0 + i ||
                out_t_gnt !== 32'd50 + i || out_t_rsp !== 32'd51 + i) begin
                bad++;
                $display("FAIL bp_drain%0d got=v%0b %0h %0h %0d/%0d exp=%0h %0h %0d/%0d", i, out_valid,
                         out_addr, out_instr, out_t_gnt, out_t_rsp, 32'h400 + 4 * i, 32'hB0 + i, 50 + i, 51 + i);
            end
            cyc(0, 0, 0, 0, 0);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b exp=0", out_valid); end
    endtask

    task automatic test_trace_en();
        counter = 32'd70;
        trace_en = 1'b0;
        cyc(1, 32'h500, 1, 0, 0);
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL te_gated got=%0d exp=0", pending_count); end
        trace_en = 1'b1;
        cyc(1, 32'h504, 0, 0, 0);           // 71: starts, waits for grant
        trace_en = 1'b0;
        cyc(1, 32'h504, 1, 0, 0);           // 72: grant completes despite trace_en low
        total++; if (pending_count !== 3'd1) begin bad++; $display("FAIL te_inflight got=%0d exp=1", pending_count); end
        cyc(0, 0, 0, 1, 32'h77);            // 73
        total++; if (out_addr !== 32'h504 || out_t_req !== 32'd71 || out_t_gnt !== 32'd72 || out_t_rsp !== 32'd73) begin bad++; $display("FAIL te_rec got=%0h %0d/%0d/%0d exp=504 71/72/73", out_addr, out_t_req, out_t_gnt, out_t_rsp); end
        trace_en = 1'b1;
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_ready = 1'b0;
        counter = 32'd59;
        cyc(0, 0, 0, 1, 0);                 // spurious, sets a flag
        cyc(1, 32'h600, 1, 0, 0);
        cyc(1, 32'h604, 1, 1, 1);
        cyc(1, 32'h608, 1, 1, 2);
        cyc(1, 32'h60C, 1, 1, 3);
        cyc(1, 32'h610, 1, 0, 0);
        total++; if (pending_count !== 3'd2 || out_valid !== 1'b1 || err_spurious !== 1'b1) begin bad++; $display("FAIL mid_pre got=p%0d v%0b s%0b exp=p2 v1 s1", pending_count, out_valid, err_spurious); end
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || pending_count !== 3'd0 || err_spurious !== 1'b0 || err_overflow !== 1'b0 || drop_count !== 16'd0 || out_addr !== 32'd0) begin bad++; $display("FAIL mid_post got=v%0b p%0d s%0b o%0b d%0d a%0h exp=all0", out_valid, pending_count, err_spurious, err_overflow, drop_count, out_addr); end
        cyc(0, 0, 0, 1, 32'h9);
        total++; if (err_spurious !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_spur got=s%0b v%0b exp=s1 v0", err_spurious, out_valid); end
        out_ready = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        trace_en     = 1'b1;
        out_ready    = 1'b1;
        instr_req    = 1'b0;
        instr_addr   = '0;
        instr_grant  = 1'b0;
        instr_rvalid = 1'b0;
        instr_rdata  = '0;
        counter      = '0;
        test_reset();
        test_single_fetch();
        test_pipelined();
        test_same_cycle();
        test_trace_en();
        test_overflow_spurious();
        test_backpressure();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_tracker_mo.md
Name: if_tracker_mo

Overview:
- Multi-outstanding successor to the single-request instruction-fetch tracker. Sits beside the core's instruction memory port and timestamps each fetch: request start, grant, and response (rvalid).
- Supports up to MAX_OUTSTANDING granted-but-unanswered fetches, then pairs responses in order.
- Completed records are queued in an output FIFO with a valid/ready handshake, so trace consumers may stall without losing records.

Parameters:
- ADDR_WIDTH, 32, instruction address width
- DATA_WIDTH, 32, instruction word width
- TIME_WIDTH, 32, width of timestamp counter and record time fields
- MAX_OUTSTANDING, 4, depth of in-order pending FIFO (power of 2, >=2)
- OUT_DEPTH, 4, depth of completed-record output FIFO (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trace_en  in  1  when low, no new requests are captured; in-flight ones still complete
- instr_req  in  1  fetch request from core
- instr_addr  in  ADDR_WIDTH  fetch address, valid with instr_req
- instr_grant  in  1  memory grant
- instr_rvalid  in  1  response valid
- instr_rdata  in  DATA_WIDTH  response data
- counter  in  TIME_WIDTH  free-running global timestamp
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head record
- out_addr  out  ADDR_WIDTH  record address
- out_instr  out  DATA_WIDTH  record instruction word
- out_t_req  out  TIME_WIDTH  request start time
- out_t_gnt  out  TIME_WIDTH  grant time
- out_t_rsp  out  TIME_WIDTH  rvalid time
- pending_count  out  $clog2(MAX_OUTSTANDING)+1  granted, unanswered entries
- err_overflow  out  1  sticky: grant while pending FIFO full
- err_spurious  out  1  sticky: rvalid with no pending entry
- drop_count  out  16  saturating count of records lost to full output FIFO

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset:
  - both FIFOs emptied; request FSM set to REQ_IDLE.
  - out_valid=0, pending_count=0, err_overflow=0, err_spurious=0, drop_count=0.
  - Record outputs = 0.
  - Reset mid-operation discards all in-flight and queued records. Responses arriving after reset for pre-reset grants count as spurious.
- Request FSM:
  - REQ_IDLE:
    - on instr_req && trace_en, t_req_reg<=counter.
    - If instr_grant in the same cycle: push immediately with t_req=t_gnt=counter, and stay in REQ_IDLE.
    - Otherwise go to REQ_WAIT_GNT.
  - REQ_WAIT_GNT: on instr_grant, push {instr_addr, t_req_reg, counter} to the pending FIFO, then go to REQ_IDLE.
  - Back-to-back: if instr_req stays high the cycle after a grant, that cycle starts a new request, timestamped with that cycle's counter.
  - trace_en is sampled only in REQ_IDLE. A request already in REQ_WAIT_GNT completes regardless.
- Pending FIFO:
  - Grant while full: entry not pushed, err_overflow<=1.
  - Pairing is in order. On instr_rvalid, pop the head and form a record {addr, rdata, t_req, t_gnt, t_rsp=counter}.
  - instr_rvalid with the FIFO empty (judged before any same-cycle push): err_spurious<=1, nothing popped.
  - A grant and an rvalid in the same cycle: the rvalid pairs with the pre-existing head; the grant pushes behind it. pending_count is unchanged.
- Output FIFO:
  - out_valid = not empty; out_* driven from the head register and stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - Record push while full and no same-cycle pop: record dropped, drop_count increments, saturating at 16'hFFFF.
  - Push while full with a same-cycle pop: accepted, no drop.
  - Push into an empty FIFO: out_valid is asserted the next cycle, giving 1-cycle latency from rvalid to out_valid.
- Arithmetic:
  - Timestamps are copied unmodified; no differences are computed.
  - FIFO pointers wrap modulo depth; full/empty use an extra pointer bit.

Test Plan:
- Single fetch: req at counter=10, grant at 12, rvalid at 14, out_ready=1 -> one record {t_req=10, t_gnt=12, t_rsp=14}; out_valid high for exactly 1 cycle, at counter 15.
- Pipelined: grants at 20, 21, 22 (req held high, addrs 0x100/0x104/0x108), rvalids at 23, 24, 25 -> three in-order records with t_req=20/21/22 and addrs matching; pending_count peaks at 3.
- Same-cycle grant and rvalid with 1 entry pending -> pending_count stays 1; the record carries the older address.
- Overflow: MAX_OUTSTANDING=4, 5 grants with no rvalid -> err_overflow=1, pending_count=4. rvalid with empty pending -> err_spurious=1.
- Backpressure: OUT_DEPTH=4, out_ready=0, 6 completions -> 4 records held, drop_count=2. Then out_ready=1 -> 4 records drain in order, with out_* stable while stalled.
- Reset asserted with 2 pending and 3 queued -> next cycle out_valid=0, pending_count=0, flags and drop_count 0. A following rvalid sets err_spurious.
